// File: rtl/adc_capture_ctrl_pkg.sv
// Shared types and constants for the ADC burst capture controller.
package adc_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [1:0] TRIG_IMM  = 2'd0;
    localparam logic [1:0] TRIG_RISE = 2'd1;
    localparam logic [1:0] TRIG_FALL = 2'd2;

    localparam int unsigned MAX_LEN_DEFAULT = 4096;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// ADC sample stream in, sample-RAM write bus out.
// adc_valid qualifies adc_data for exactly the cycle it is high; there is no back-pressure.
interface adc_capture_ctrl_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 16
);
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;

    modport master (input adc_data, input adc_valid, output ram_addr, output ram_data);
    modport slave  (output adc_data, output adc_valid, input ram_addr, input ram_data);
endinterface

// File: rtl/adc_capture_ctrl_trig_detect.sv
// Threshold-crossing trigger: remembers the previous armed sample and flags the crossing sample.
module adc_trig_detect
    import adc_cap_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_level,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_trig_hit
);
    logic [DATA_W-1:0] r_prev;
    logic              r_prev_valid;
    logic              w_cond;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_en && i_valid) begin
            r_prev       <= i_data;
            r_prev_valid <= 1'b1;
        end
    end

    // Reserved mode 3 falls into the default and behaves as immediate.
    always_comb begin
        w_cond = 1'b1;
        case (i_mode)
            TRIG_RISE: w_cond = r_prev_valid && (r_prev < i_level) && (i_data >= i_level);
            TRIG_FALL: w_cond = r_prev_valid && (r_prev > i_level) && (i_data <= i_level);
            default:   w_cond = 1'b1;
        endcase
        o_trig_hit = i_en && i_valid && w_cond;
    end
endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered, decimated burst capture of an ADC stream into the sample RAM.
// ram_addr falling to 0 marks the end of a capture for the downstream reader.
module adc_capture_ctrl
    import adc_cap_pkg::*;
#(
    parameter int          DATA_W  = 12,
    parameter int          ADDR_W  = 16,
    parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT,
    parameter int          DECIM_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [ADDR_W-1:0]   i_capture_len,
    input  logic [DECIM_W-1:0]  i_decim,
    input  logic [1:0]          i_trig_mode,
    input  logic [DATA_W-1:0]   i_trig_level,
    adc_capture_ctrl_if.master  bus,
    output logic [ADDR_W-1:0]   o_read_length,
    output logic                o_busy,
    output logic                o_done,
    output state_t              o_dbg_state
);
    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_len, w_len_nxt;
    logic [DECIM_W-1:0]  r_decim, w_decim_nxt;
    logic [DECIM_W-1:0]  r_dcnt, w_dcnt_nxt;
    logic [1:0]          r_mode, w_mode_nxt;
    logic [DATA_W-1:0]   r_level, w_level_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic [ADDR_W-1:0]   r_rlen, w_rlen_nxt;
    logic                r_done, w_done_nxt;
    logic                r_fin, w_fin_nxt;
    logic                w_arm;
    logic                w_trig_hit;
    logic [ADDR_W-1:0]   w_len_clamped;

    assign w_len_clamped = (i_capture_len > ADDR_W'(MAX_LEN)) ? ADDR_W'(MAX_LEN) : i_capture_len;

    adc_trig_detect #(.DATA_W(DATA_W)) u_trig (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_arm),
        .i_en       (r_state == ARMED),
        .i_mode     (r_mode),
        .i_level    (r_level),
        .i_data     (bus.adc_data),
        .i_valid    (bus.adc_valid),
        .o_trig_hit (w_trig_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_decim <= '0;
            r_dcnt  <= '0;
            r_mode  <= '0;
            r_level <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_rlen  <= '0;
            r_done  <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_decim <= w_decim_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_mode  <= w_mode_nxt;
            r_level <= w_level_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_rlen  <= w_rlen_nxt;
            r_done  <= w_done_nxt;
            r_fin   <= w_fin_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_decim_nxt = r_decim;
        w_dcnt_nxt  = r_dcnt;
        w_mode_nxt  = r_mode;
        w_level_nxt = r_level;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_rlen_nxt  = r_rlen;
        w_done_nxt  = 1'b0;
        w_fin_nxt   = r_fin;
        w_arm       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && (w_len_clamped != '0)) begin
                    w_arm       = 1'b1;
                    w_len_nxt   = w_len_clamped;
                    w_decim_nxt = i_decim;
                    w_mode_nxt  = i_trig_mode;
                    w_level_nxt = i_trig_level;
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (i_abort) begin
                    w_state_nxt = IDLE;
                end else if (w_trig_hit) begin
                    // The trigger sample is sample 1 and consumes decimation slot 0.
                    w_addr_nxt  = ADDR_W'(1);
                    w_data_nxt  = bus.adc_data;
                    w_dcnt_nxt  = (r_decim == '0) ? '0 : DECIM_W'(1);
                    w_fin_nxt   = 1'b0;
                    w_state_nxt = (r_len == ADDR_W'(1)) ? FINISH : CAPTURE;
                end
            end
            CAPTURE: begin
                if (i_abort) begin
                    w_addr_nxt  = '0;
                    w_rlen_nxt  = r_addr;
                    w_done_nxt  = (r_addr != '0);
                    w_state_nxt = IDLE;
                end else if (bus.adc_valid) begin
                    w_dcnt_nxt = (r_dcnt == r_decim) ? '0 : r_dcnt + 1'b1;
                    if (r_dcnt == '0) begin
                        w_addr_nxt = r_addr + 1'b1;
                        w_data_nxt = bus.adc_data;
                        if ((r_addr + 1'b1) == r_len) begin
                            w_fin_nxt   = 1'b0;
                            w_state_nxt = FINISH;
                        end
                    end
                end
            end
            FINISH: begin
                // Hold the last address one extra cycle, then release it as the end marker.
                if (!r_fin) begin
                    w_fin_nxt = 1'b1;
                end else begin
                    w_addr_nxt  = '0;
                    w_rlen_nxt  = r_len;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.ram_addr  = r_addr;
    assign bus.ram_data  = r_data;
    assign o_read_length = r_rlen;
    assign o_done        = r_done;
    assign o_busy        = (r_state == ARMED) || (r_state == CAPTURE);
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: directed scenarios plus randomized captures
// checked cycle by cycle against a sample-list reference model.
module tb_adc_capture_ctrl;
    import adc_cap_pkg::*;

    localparam int DW = 12;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] capture_len = '0;
    logic [7:0]    decim = '0;
    logic [1:0]    trig_mode = '0;
    logic [DW-1:0] trig_level = '0;
    logic [AW-1:0] read_length;
    logic          busy;
    logic          done;
    state_t        dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int fall_cnt = 0;
    int done_cnt = 0;
    int rlen_m = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] d_q[$];

    adc_capture_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    adc_capture_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_capture_len (capture_len),
        .i_decim       (decim),
        .i_trig_mode   (trig_mode),
        .i_trig_level  (trig_level),
        .bus           (bus),
        .o_read_length (read_length),
        .o_busy        (busy),
        .o_done        (done),
        .o_dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // Count end-of-capture markers independently of the per-cycle checks.
    always @(negedge clk) begin
        if (prev_addr != '0 && bus.ram_addr == '0) fall_cnt++;
        if (done) done_cnt++;
        prev_addr = bus.ram_addr;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Index of the trigger sample in d_q, or -1 when no trigger occurs.
    function automatic int find_trig(input int mode, input int lvl);
        for (int i = 0; i < d_q.size(); i++) begin
            if (mode == 1) begin
                if (i > 0 && int'(d_q[i-1]) < lvl && int'(d_q[i]) >= lvl) return i;
            end else if (mode == 2) begin
                if (i > 0 && int'(d_q[i-1]) > lvl && int'(d_q[i]) <= lvl) return i;
            end else begin
                return i;
            end
        end
        return -1;
    endfunction

    task automatic run_cap(input int len, input int dec, input int mode, input int lvl,
                           input int gap, input int abort_idx, input bit start_mid);
        int n, t, k, last_k, f0, d0, ndec, i;
        logic [DW-1:0] last_d;
        bit fin;
        n = (len > 4096) ? 4096 : len;
        ndec = dec + 1;
        t = find_trig(mode, lvl);
        f0 = fall_cnt;
        d0 = done_cnt;
        last_k = 0;
        last_d = '0;
        fin = 1'b0;
        start = 1'b1;
        capture_len = AW'(len);
        decim = 8'(dec);
        trig_mode = 2'(mode);
        trig_level = DW'(lvl);
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 32'(n > 0));
        chk("start_addr", bus.ram_addr, 0);
        if (n == 0) begin
            repeat (3) begin
                bus.adc_valid = 1'b1;
                bus.adc_data = DW'($urandom);
                @(negedge clk);
                chk("len0_busy", busy, 0);
                chk("len0_addr", bus.ram_addr, 0);
                chk("len0_state", dbg_state, IDLE);
            end
            bus.adc_valid = 1'b0;
            chk("len0_rlen", read_length, rlen_m);
            return;
        end
        i = 0;
        while (i < d_q.size() && !fin && i != abort_idx) begin
            bus.adc_valid = 1'b1;
            bus.adc_data = d_q[i];
            if (start_mid && i == 1) begin
                start = 1'b1;
                capture_len = AW'(1);
            end
            @(negedge clk);
            bus.adc_valid = 1'b0;
            start = 1'b0;
            k = (t >= 0 && i >= t && (i - t) % ndec == 0 && (i - t) / ndec < n) ? (i - t) / ndec + 1 : 0;
            if (k > 0) begin
                last_k = k;
                last_d = d_q[i];
            end
            chk("addr", bus.ram_addr, last_k);
            if (last_k > 0) chk("data", bus.ram_data, last_d);
            chk("done_mid", done, 0);
            if (k == n) fin = 1'b1;
            else chk("busy_mid", busy, 1);
            for (int g = 0; g < gap && !fin; g++) begin
                @(negedge clk);
                chk("hold_addr", bus.ram_addr, last_k);
                if (last_k > 0) chk("hold_data", bus.ram_data, last_d);
                chk("hold_busy", busy, 1);
            end
            i++;
        end
        if (fin) begin
            @(negedge clk);
            chk("fin_hold", bus.ram_addr, n);
            chk("fin_hold_done", done, 0);
            @(negedge clk);
            rlen_m = n;
            chk("fin_addr0", bus.ram_addr, 0);
            chk("fin_done", done, 1);
            chk("fin_rlen", read_length, rlen_m);
            chk("fin_busy", busy, 0);
        end else begin
            abort = 1'b1;
            if (i < d_q.size()) begin
                bus.adc_valid = 1'b1;
                bus.adc_data = d_q[i];
            end
            @(negedge clk);
            abort = 1'b0;
            bus.adc_valid = 1'b0;
            if (last_k > 0) rlen_m = last_k;
            chk("abort_addr", bus.ram_addr, 0);
            chk("abort_done", done, 32'(last_k > 0));
            chk("abort_rlen", read_length, rlen_m);
            chk("abort_busy", busy, 0);
        end
        @(negedge clk);
        chk("idle_addr", bus.ram_addr, 0);
        chk("idle_done", done, 0);
        chk("idle_state", dbg_state, IDLE);
        chk("falls", fall_cnt - f0, 32'(last_k > 0));
        chk("done_pulses", done_cnt - d0, 32'(last_k > 0));
    endtask

    initial begin
        bus.adc_valid = 1'b0;
        bus.adc_data = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_data", bus.ram_data, 0);
        chk("rst_rlen", read_length, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        @(negedge clk);

        d_q = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
        run_cap(5, 0, 0, 0, 0, -1, 1'b0);

        d_q = '{12'h7F0, 12'h7FF, 12'h800, 12'h810};
        run_cap(2, 0, 1, 'h800, 0, -1, 1'b0);

        d_q = '{12'h900, 12'h850, 12'h7A0, 12'h820, 12'h830};
        run_cap(2, 0, 1, 'h800, 0, -1, 1'b0);

        d_q = '{12'h100, 12'h900, 12'h800, 12'h7FF};
        run_cap(2, 0, 2, 'h800, 0, -1, 1'b0);

        d_q.delete();
        for (int v = 0; v < 9; v++) d_q.push_back(DW'(v));
        run_cap(3, 2, 0, 0, 2, -1, 1'b0);

        d_q.delete();
        for (int v = 0; v < 10; v++) d_q.push_back(DW'(v + 16));
        run_cap(10, 0, 0, 0, 0, 2, 1'b0);

        d_q = '{12'h900, 12'h950, 12'h990};
        run_cap(4, 0, 1, 'h800, 0, -1, 1'b0);

        run_cap(0, 0, 0, 0, 0, -1, 1'b0);

        d_q = '{12'h011, 12'h022, 12'h033, 12'h044, 12'h055, 12'h066};
        run_cap(6, 0, 0, 0, 1, -1, 1'b1);

        d_q.delete();
        for (int v = 0; v < 4096; v++) d_q.push_back(DW'($urandom));
        run_cap('hFFFF, 0, 0, 0, 0, -1, 1'b0);

        start = 1'b1;
        capture_len = AW'(8);
        decim = '0;
        trig_mode = 2'd0;
        @(negedge clk);
        start = 1'b0;
        for (int v = 0; v < 3; v++) begin
            bus.adc_valid = 1'b1;
            bus.adc_data = DW'(v + 'h100);
            @(negedge clk);
        end
        chk("pre_rst_addr", bus.ram_addr, 3);
        rst = 1'b1;
        @(negedge clk);
        bus.adc_valid = 1'b0;
        rst = 1'b0;
        rlen_m = 0;
        chk("midrst_addr", bus.ram_addr, 0);
        chk("midrst_data", bus.ram_data, 0);
        chk("midrst_rlen", read_length, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_state", dbg_state, IDLE);
        @(negedge clk);
        d_q = '{12'hABC, 12'hDEF, 12'h123};
        run_cap(3, 0, 0, 0, 0, -1, 1'b0);

        for (int r = 0; r < 25; r++) begin
            d_q.delete();
            for (int v = 0; v < 40; v++) d_q.push_back(DW'($urandom));
            run_cap($urandom_range(1, 8), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 4095), $urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 39) : -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
